// File: rtl/hls_kernel_launcher.sv
// Launch sequencer: writes kernel scalar args over AXI-lite, sets ap_start, polls ap_done, reports elapsed cycles.
// Optional poll timeout is enabled by defining HLS_LAUNCH_TIMEOUT_EN.
module hls_kernel_launcher #(
  parameter int NUM_ARGS       = 2,
  parameter int AXI_ADDR_BITS  = 6,
  parameter int AXI_DATA_BITS  = 32,
  parameter int ARG_BASE       = 'h10,
  parameter int ARG_STRIDE     = 8,
  parameter int POLL_GAP       = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       launch_valid,
  output logic                       launch_ready,
  input  logic [32*NUM_ARGS-1:0]     launch_args,
  output logic                       done_valid,
  output logic                       done_error,
  output logic [31:0]                done_cycles,
  output logic                       s_axi_control_AWVALID,
  input  logic                       s_axi_control_AWREADY,
  output logic [AXI_ADDR_BITS-1:0]   s_axi_control_AWADDR,
  output logic                       s_axi_control_WVALID,
  input  logic                       s_axi_control_WREADY,
  output logic [AXI_DATA_BITS-1:0]   s_axi_control_WDATA,
  output logic [3:0]                 s_axi_control_WSTRB,
  input  logic                       s_axi_control_BVALID,
  output logic                       s_axi_control_BREADY,
  input  logic [1:0]                 s_axi_control_BRESP,
  output logic                       s_axi_control_ARVALID,
  input  logic                       s_axi_control_ARREADY,
  output logic [AXI_ADDR_BITS-1:0]   s_axi_control_ARADDR,
  input  logic                       s_axi_control_RVALID,
  output logic                       s_axi_control_RREADY,
  input  logic [AXI_DATA_BITS-1:0]   s_axi_control_RDATA,
  input  logic [1:0]                 s_axi_control_RRESP,
  output logic [3:0]                 dbg_state
);

  localparam logic [3:0] IDLE          = 4'd0;
  localparam logic [3:0] ARG_AW        = 4'd1;
  localparam logic [3:0] ARG_W         = 4'd2;
  localparam logic [3:0] ARG_B         = 4'd3;
  localparam logic [3:0] START_AW      = 4'd4;
  localparam logic [3:0] START_W       = 4'd5;
  localparam logic [3:0] START_B       = 4'd6;
  localparam logic [3:0] POLL_AR       = 4'd7;
  localparam logic [3:0] POLL_R        = 4'd8;
  localparam logic [3:0] POLL_GAP_WAIT = 4'd9;
  localparam logic [3:0] DONE          = 4'd10;

  localparam int IDX_W = (NUM_ARGS > 1) ? $clog2(NUM_ARGS) : 1;

  // Handshake rule: every VALID is a pure function of state, so it and its
  // address/data stay put until READY is sampled high at a clock edge.
  logic [3:0]       state;
  logic [IDX_W-1:0] arg_idx;
  logic [31:0]      args_q [NUM_ARGS];
  logic [31:0]      cyc_cnt;
  logic [31:0]      cyc_next;
  logic [7:0]       gap_cnt;
  logic [31:0]      arg_addr;
  logic             unused_rdata;

  assign cyc_next = (cyc_cnt == 32'hFFFF_FFFF) ? cyc_cnt : cyc_cnt + 32'd1;
  assign arg_addr = 32'(ARG_BASE) + 32'(arg_idx) * 32'(ARG_STRIDE);
  assign unused_rdata = ^{s_axi_control_RDATA[AXI_DATA_BITS-1:2], s_axi_control_RDATA[0]};

`ifndef HLS_LAUNCH_TIMEOUT_EN
  localparam int unused_timeout = TIMEOUT_CYCLES;
`endif

  assign dbg_state             = state;
  assign launch_ready          = (state == IDLE);
  assign done_valid            = (state == DONE);
  assign s_axi_control_AWVALID = (state == ARG_AW) || (state == START_AW);
  assign s_axi_control_AWADDR  = (state == ARG_AW) ? arg_addr[AXI_ADDR_BITS-1:0] : '0;
  assign s_axi_control_WVALID  = (state == ARG_W) || (state == START_W);
  assign s_axi_control_WDATA   = (state == ARG_W)   ? AXI_DATA_BITS'(args_q[arg_idx]) :
                                 (state == START_W) ? AXI_DATA_BITS'(1) : '0;
  assign s_axi_control_WSTRB   = s_axi_control_WVALID ? 4'hF : 4'h0;
  assign s_axi_control_BREADY  = (state == ARG_B) || (state == START_B);
  assign s_axi_control_ARVALID = (state == POLL_AR);
  assign s_axi_control_ARADDR  = '0;
  assign s_axi_control_RREADY  = (state == POLL_R);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      arg_idx     <= '0;
      cyc_cnt     <= '0;
      gap_cnt     <= '0;
      done_error  <= 1'b0;
      done_cycles <= '0;
      for (int i = 0; i < NUM_ARGS; i++) args_q[i] <= '0;
    end else begin
      case (state)
        IDLE: if (launch_valid) begin
          for (int i = 0; i < NUM_ARGS; i++) args_q[i] <= launch_args[32*i +: 32];
          arg_idx <= '0;
          state   <= ARG_AW;
        end
        ARG_AW: if (s_axi_control_AWREADY) state <= ARG_W;
        ARG_W:  if (s_axi_control_WREADY)  state <= ARG_B;
        ARG_B: if (s_axi_control_BVALID) begin
          if (s_axi_control_BRESP != 2'b00) begin
            done_error  <= 1'b1;
            done_cycles <= '0;
            state       <= DONE;
          end else if (arg_idx == IDX_W'(NUM_ARGS - 1)) begin
            state <= START_AW;
          end else begin
            arg_idx <= arg_idx + 1'b1;
            state   <= ARG_AW;
          end
        end
        START_AW: if (s_axi_control_AWREADY) state <= START_W;
        START_W:  if (s_axi_control_WREADY)  state <= START_B;
        START_B: if (s_axi_control_BVALID) begin
          if (s_axi_control_BRESP != 2'b00) begin
            done_error  <= 1'b1;
            done_cycles <= '0;
            state       <= DONE;
          end else begin
            cyc_cnt <= '0;
            state   <= POLL_AR;
          end
        end
        POLL_AR: begin
          cyc_cnt <= cyc_next;
          if (s_axi_control_ARREADY) state <= POLL_R;
        end
        POLL_R: begin
          cyc_cnt <= cyc_next;
          if (s_axi_control_RVALID) begin
            if (s_axi_control_RRESP != 2'b00) begin
              done_error  <= 1'b1;
              done_cycles <= cyc_next;
              state       <= DONE;
            end else if (s_axi_control_RDATA[1]) begin
              done_error  <= 1'b0;
              done_cycles <= cyc_next;
              state       <= DONE;
`ifdef HLS_LAUNCH_TIMEOUT_EN
            end else if (cyc_next >= 32'(TIMEOUT_CYCLES)) begin
              done_error  <= 1'b1;
              done_cycles <= 32'(TIMEOUT_CYCLES);
              state       <= DONE;
`endif
            end else if (POLL_GAP == 0) begin
              state <= POLL_AR;
            end else begin
              gap_cnt <= '0;
              state   <= POLL_GAP_WAIT;
            end
          end
        end
        POLL_GAP_WAIT: begin
          cyc_cnt <= cyc_next;
`ifdef HLS_LAUNCH_TIMEOUT_EN
          if (cyc_next >= 32'(TIMEOUT_CYCLES)) begin
            done_error  <= 1'b1;
            done_cycles <= 32'(TIMEOUT_CYCLES);
            state       <= DONE;
          end else
`endif
          if (gap_cnt == 8'(POLL_GAP - 1)) state <= POLL_AR;
          else gap_cnt <= gap_cnt + 8'd1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hls_kernel_launcher.sv
// Directed bench for hls_kernel_launcher: behavioural AXI-lite slave with stall/error knobs,
// write scoreboard and hand-computed latency / cycle-count expectations.
module tb_hls_kernel_launcher;

  localparam int AW = 6;
  localparam int DW = 32;
`ifdef HLS_LAUNCH_TIMEOUT_EN
  localparam int TB_TIMEOUT = 100;
`else
  localparam int TB_TIMEOUT = 65535;
`endif

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic          launch_valid = 1'b0;
  logic          launch_ready;
  logic [63:0]   launch_args = '0;
  logic          done_valid, done_error;
  logic [31:0]   done_cycles;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [AW-1:0] awaddr, araddr;
  logic [DW-1:0] wdata, rdata;
  logic [3:0]    wstrb, dbg_state;
  logic [1:0]    bresp, rresp;

  hls_kernel_launcher #(.NUM_ARGS(2), .POLL_GAP(4), .TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .clock(clock), .reset(reset),
    .launch_valid(launch_valid), .launch_ready(launch_ready), .launch_args(launch_args),
    .done_valid(done_valid), .done_error(done_error), .done_cycles(done_cycles),
    .s_axi_control_AWVALID(awvalid), .s_axi_control_AWREADY(awready), .s_axi_control_AWADDR(awaddr),
    .s_axi_control_WVALID(wvalid), .s_axi_control_WREADY(wready), .s_axi_control_WDATA(wdata),
    .s_axi_control_WSTRB(wstrb),
    .s_axi_control_BVALID(bvalid), .s_axi_control_BREADY(bready), .s_axi_control_BRESP(bresp),
    .s_axi_control_ARVALID(arvalid), .s_axi_control_ARREADY(arready), .s_axi_control_ARADDR(araddr),
    .s_axi_control_RVALID(rvalid), .s_axi_control_RREADY(rready), .s_axi_control_RDATA(rdata),
    .s_axi_control_RRESP(rresp),
    .dbg_state(dbg_state)
  );

  // slave knobs and observations
  int aw_stall = 0, w_stall = 0, aw_wait = 0, w_wait = 0;
  int bresp_err_idx = -1, rresp_err_poll = -1, done_poll = 1;
  int wr_count = 0, rd_count = 0;
  bit overlap_seen = 0, stable_err = 0, strb_err = 0, araddr_err = 0;
  bit prev_awv = 0, prev_wv = 0;
  logic [AW-1:0] prev_awaddr = '0, awaddr_q = '0;
  logic [DW-1:0] prev_wdata = '0;
  logic [AW+DW-1:0] obs_q[$];
  logic [AW+DW-1:0] exp_q[$];

  int n_cmp = 0, n_fail = 0;

  // Slave decides READY/VALID for the upcoming edge on each falling edge.
  always @(negedge clock or posedge reset) begin
    if (reset) begin
      awready = 0; wready = 0; bvalid = 0; bresp = 0;
      arready = 0; rvalid = 0; rdata = 0; rresp = 0;
      aw_wait = 0; w_wait = 0; prev_awv = 0; prev_wv = 0;
    end else begin
      if (awvalid && wvalid) overlap_seen = 1;
      if (awvalid && prev_awv && awaddr !== prev_awaddr) stable_err = 1;
      if (wvalid && prev_wv && wdata !== prev_wdata) stable_err = 1;
      if (wvalid && wstrb !== 4'hF) strb_err = 1;
      if (arvalid && araddr !== '0) araddr_err = 1;
      if (awvalid) begin
        awready = (aw_wait >= aw_stall);
        if (!awready) aw_wait++;
      end else begin
        awready = 0; aw_wait = 0;
      end
      if (awvalid && awready) awaddr_q = awaddr;
      if (wvalid) begin
        wready = (w_wait >= w_stall);
        if (!wready) w_wait++;
      end else begin
        wready = 0; w_wait = 0;
      end
      if (wvalid && wready) begin
        obs_q.push_back({awaddr_q, wdata});
        wr_count++;
      end
      bvalid = bready;
      bresp  = (bready && (wr_count - 1 == bresp_err_idx)) ? 2'b10 : 2'b00;
      arready = arvalid;
      if (arvalid) rd_count++;
      rvalid = rready;
      rdata  = (rready && rd_count == done_poll) ? 32'h2 : 32'h0;
      rresp  = (rready && rd_count == rresp_err_poll) ? 2'b10 : 2'b00;
      prev_awv = awvalid && !awready; prev_awaddr = awaddr;
      prev_wv  = wvalid && !wready;   prev_wdata  = wdata;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_slave();
    wr_count = 0; rd_count = 0; obs_q.delete(); exp_q.delete();
    aw_stall = 0; w_stall = 0; bresp_err_idx = -1; rresp_err_poll = -1; done_poll = 1;
    overlap_seen = 0; stable_err = 0; strb_err = 0; araddr_err = 0;
  endtask

  task automatic launch(input logic [31:0] a0, input logic [31:0] a1);
    @(negedge clock);
    launch_valid = 1'b1;
    launch_args  = {a1, a0};
    @(posedge clock);
    #1 launch_valid = 1'b0;
  endtask

  // Cycle k = k-th falling edge after the accepting edge.
  task automatic wait_done(input int start, input int limit, output int lat, output bit found);
    lat = 0; found = 0;
    for (int k = start; k <= limit; k++) begin
      @(negedge clock);
      if (done_valid) begin
        lat = k; found = 1;
        break;
      end
    end
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_nwr"}, 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check({tag, "_wr"}, 64'(obs_q[i]), 64'(exp_q[i]));
  endtask

  int lat;
  bit found;

  initial begin
    // reset state
    #12;
    check("rst_ready", 64'(launch_ready), 64'd1);
    check("rst_done_valid", 64'(done_valid), 64'd0);
    check("rst_done_error", 64'(done_error), 64'd0);
    check("rst_done_cycles", 64'(done_cycles), 64'd0);
    check("rst_valids", 64'({awvalid, wvalid, arvalid, bready, rready}), 64'd0);
    check("rst_awaddr", 64'(awaddr), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    @(negedge clock); reset = 1'b0;

    // T1: args 5/7, done on third poll
    clear_slave(); done_poll = 3;
    exp_q.push_back({6'h10, 32'h5}); exp_q.push_back({6'h18, 32'h7}); exp_q.push_back({6'h00, 32'h1});
    launch(32'h5, 32'h7);
    @(negedge clock);
    check("t1_aw_first_cycle", 64'(awvalid), 64'd1);
    check("t1_awaddr0", 64'(awaddr), 64'h10);
    wait_done(2, 200, lat, found);
    check("t1_found", 64'(found), 64'd1);
    check("t1_latency", 64'(lat), 64'd24);
    check("t1_error", 64'(done_error), 64'd0);
    check("t1_cycles", 64'(done_cycles), 64'd14);
    check("t1_reads", 64'(rd_count), 64'd3);
    check("t1_strb", 64'(strb_err), 64'd0);
    check("t1_araddr", 64'(araddr_err), 64'd0);
    check_writes("t1");
    @(negedge clock);
    check("t1_pulse_one_cycle", 64'(done_valid), 64'd0);
    check("t1_cycles_held", 64'(done_cycles), 64'd14);
    check("t1_ready_again", 64'(launch_ready), 64'd1);

    // T2: minimum launch-to-done
    clear_slave(); done_poll = 1;
    launch(32'hDEAD_BEEF, 32'h1234_5678);
    wait_done(1, 200, lat, found);
    check("t2_found", 64'(found), 64'd1);
    check("t2_latency", 64'(lat), 64'd12);
    check("t2_cycles", 64'(done_cycles), 64'd2);
    check("t2_error", 64'(done_error), 64'd0);

    // T3: AW stalls 5, W stalls 3
    clear_slave(); aw_stall = 5; w_stall = 3; done_poll = 1;
    exp_q.push_back({6'h10, 32'hA5A5_0001}); exp_q.push_back({6'h18, 32'h5A5A_0002}); exp_q.push_back({6'h00, 32'h1});
    launch(32'hA5A5_0001, 32'h5A5A_0002);
    wait_done(1, 400, lat, found);
    check("t3_found", 64'(found), 64'd1);
    check("t3_latency", 64'(lat), 64'd36);
    check("t3_overlap", 64'(overlap_seen), 64'd0);
    check("t3_stable", 64'(stable_err), 64'd0);
    check("t3_error", 64'(done_error), 64'd0);
    check_writes("t3");

    // T4: BRESP error on argument 1
    clear_slave(); bresp_err_idx = 1;
    launch(32'h11, 32'h22);
    wait_done(1, 200, lat, found);
    check("t4_found", 64'(found), 64'd1);
    check("t4_latency", 64'(lat), 64'd7);
    check("t4_error", 64'(done_error), 64'd1);
    check("t4_no_start", 64'(wr_count), 64'd2);

    // T5: RRESP error on second poll
    clear_slave(); done_poll = 0; rresp_err_poll = 2;
    launch(32'h3, 32'h4);
    wait_done(1, 200, lat, found);
    check("t5_found", 64'(found), 64'd1);
    check("t5_error", 64'(done_error), 64'd1);
    check("t5_reads", 64'(rd_count), 64'd2);
    repeat (10) @(negedge clock);
    check("t5_no_more_ar", 64'(rd_count), 64'd2);
    check("t5_arvalid", 64'(arvalid), 64'd0);

    // T6: async reset while in POLL_R, then a normal launch
    clear_slave(); done_poll = 0;
    launch(32'h1, 32'h2);
    found = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clock);
      if (dbg_state == 4'd8) begin found = 1; break; end
    end
    check("t6_reached_poll_r", 64'(found), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("t6_rst_state", 64'(dbg_state), 64'd0);
    check("t6_rst_ready", 64'(launch_ready), 64'd1);
    check("t6_rst_outputs", 64'({rready, arvalid, awvalid, wvalid, bready, done_valid}), 64'd0);
    check("t6_rst_done", 64'({done_error, done_cycles}), 64'd0);
    @(negedge clock); #1 reset = 1'b0;
    clear_slave(); done_poll = 1;
    exp_q.push_back({6'h10, 32'h9}); exp_q.push_back({6'h18, 32'hA}); exp_q.push_back({6'h00, 32'h1});
    launch(32'h9, 32'hA);
    wait_done(1, 200, lat, found);
    check("t6_found", 64'(found), 64'd1);
    check("t6_latency", 64'(lat), 64'd12);
    check("t6_cycles", 64'(done_cycles), 64'd2);
    check_writes("t6");

    // T7: ap_done never set
    clear_slave(); done_poll = 0;
    launch(32'h0, 32'h0);
`ifdef HLS_LAUNCH_TIMEOUT_EN
    wait_done(1, 2000, lat, found);
    check("t7_found", 64'(found), 64'd1);
    check("t7_error", 64'(done_error), 64'd1);
    check("t7_cycles", 64'(done_cycles), 64'd100);
`else
    wait_done(1, 10000, lat, found);
    check("t7_no_done", 64'(found), 64'd0);
    check("t7_polling", 64'(dbg_state >= 4'd7 && dbg_state <= 4'd9), 64'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
